// File: rtl/ser2par_pkg.sv
// Shared types and width helpers for the framed serial-to-parallel receiver.
package ser2par_pkg;

   typedef enum logic {
      ASSEMBLE = 1'b0,
      HUNT     = 1'b1
   } state_t;

   // Width needed to index n distinct values, never less than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit.
module sync_fifo
   import ser2par_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [width_of(DEPTH):0] count
);
   localparam int AW = width_of(DEPTH);

   logic [AW:0]      r_wr, r_rd;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push, w_do_pop;

   assign empty = (r_wr == r_rd);
   assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign count = r_wr - r_rd;
   assign dout  = r_mem[r_rd[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= din;
            r_wr                <= r_wr + 1'b1;
         end
         if (w_do_pop) r_rd <= r_rd + 1'b1;
      end
   end

endmodule

// File: rtl/ser2par_fifo.sv
// Serial receiver: frames words on the end-of-word marker, checks length,
// and queues good words into a FWFT FIFO with a valid/ready consumer port.
module ser2par_fifo
   import ser2par_pkg::*;
#(
   parameter int WORD_SIZE  = 8,
   parameter int MSB_FIRST  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               bit_en,
   input  logic                               serial_in,
   input  logic                               lsb_in,
   output logic [WORD_SIZE-1:0]               parallel_out,
   output logic                               valid,
   input  logic                               ready,
   output logic                               frame_err,
   output logic                               overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
   localparam int                CNT_W = width_of(WORD_SIZE);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_SIZE - 1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [WORD_SIZE-1:0] r_sh, w_sh_next;
   logic                 r_frame_err, r_overflow;
   logic                 w_at_last, w_word_done, w_full, w_empty, w_pop;

   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign w_sh_next = {r_sh[WORD_SIZE-2:0], serial_in};
      end else begin : g_lsb
         assign w_sh_next = {serial_in, r_sh[WORD_SIZE-1:1]};
      end
   endgenerate

   assign w_at_last   = (r_bit_cnt == LAST);
   assign w_word_done = bit_en & lsb_in & w_at_last & (r_state == ASSEMBLE);
   assign w_pop       = ~w_empty & ready;

   assign valid     = ~w_empty;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ASSEMBLE;
         r_bit_cnt   <= '0;
         r_sh        <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (bit_en) begin
            r_sh <= w_sh_next;
            case (r_state)
               ASSEMBLE: begin
                  if (lsb_in) begin
                     r_bit_cnt   <= '0;
                     r_frame_err <= ~w_at_last;
                  end else if (w_at_last) begin
                     r_bit_cnt   <= '0;
                     r_frame_err <= 1'b1;
                     r_state     <= HUNT;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               HUNT: begin
                  // Marker bit realigns framing but is not part of any word.
                  if (lsb_in) begin
                     r_state   <= ASSEMBLE;
                     r_bit_cnt <= '0;
                  end
               end
               default: r_state <= ASSEMBLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_overflow <= 1'b0;
      else          r_overflow <= w_word_done & w_full & ~w_pop;
   end

   sync_fifo #(
      .WIDTH (WORD_SIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (w_word_done),
      .din     (w_sh_next),
      .pop     (w_pop),
      .dout    (parallel_out),
      .full    (w_full),
      .empty   (w_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_ser2par_fifo.sv
// Scoreboard bench: an MSB-first and an LSB-first receiver share one serial stream.
module tb_ser2par_fifo;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0, bit_en = 1'b0, serial_in = 1'b0, lsb_in = 1'b0, ready = 1'b0;
   logic [7:0] po_m, po_l;
   logic       v_m, v_l, fe_m, fe_l, ov_m, ov_l;
   logic [2:0] cnt_m, cnt_l;

   int checks = 0, errors = 0;
   int fe_n_m = 0, fe_n_l = 0, ov_n_m = 0, ov_n_l = 0;
   logic [7:0] q_m[$], q_l[$];

   always #5 clk = ~clk;

   ser2par_fifo #(.WORD_SIZE(8), .MSB_FIRST(1), .FIFO_DEPTH(4)) u_m (
      .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .serial_in(serial_in), .lsb_in(lsb_in),
      .parallel_out(po_m), .valid(v_m), .ready(ready), .frame_err(fe_m), .overflow(ov_m),
      .fifo_count(cnt_m));

   ser2par_fifo #(.WORD_SIZE(8), .MSB_FIRST(0), .FIFO_DEPTH(4)) u_l (
      .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .serial_in(serial_in), .lsb_in(lsb_in),
      .parallel_out(po_l), .valid(v_l), .ready(ready), .frame_err(fe_l), .overflow(ov_l),
      .fifo_count(cnt_l));

   function automatic logic [7:0] rev8(input logic [7:0] d);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[7-i];
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: every accepted head word is compared with the scoreboard.
   always @(negedge clk) begin
      if (v_m && ready) begin
         checks++;
         if (q_m.size() == 0) begin
            errors++;
            $display("FAIL word_msb unexpected got %h expected none", po_m);
         end else begin
            logic [7:0] e;
            e = q_m.pop_front();
            if (po_m !== e) begin
               errors++;
               $display("FAIL word_msb got %h expected %h", po_m, e);
            end
         end
      end
      if (v_l && ready) begin
         checks++;
         if (q_l.size() == 0) begin
            errors++;
            $display("FAIL word_lsb unexpected got %h expected none", po_l);
         end else begin
            logic [7:0] e;
            e = q_l.pop_front();
            if (po_l !== e) begin
               errors++;
               $display("FAIL word_lsb got %h expected %h", po_l, e);
            end
         end
      end
      if (fe_m) fe_n_m++;
      if (fe_l) fe_n_l++;
      if (ov_m) ov_n_m++;
      if (ov_l) ov_n_l++;
   end

   task automatic send_bit(input logic b, input logic last);
      bit_en    = 1'b1;
      serial_in = b;
      lsb_in    = last;
      @(posedge clk); #1;
      bit_en = 1'b0;
      lsb_in = 1'b0;
   endtask

   // lsbf selects transmit order; expectations follow from each receiver's order.
   task automatic send_word(input logic [7:0] d, input bit lsbf, input int nbits,
                            input bit mark, input bit exp, input bit raise_rdy);
      if (exp) begin
         q_m.push_back(lsbf ? rev8(d) : d);
         q_l.push_back(lsbf ? d : rev8(d));
      end
      for (int i = 0; i < nbits; i++) begin
         if (raise_rdy && i == nbits - 1) ready = 1'b1;
         send_bit(lsbf ? d[i] : d[7-i], mark && (i == nbits - 1));
      end
   endtask

   task automatic wait_drained(input string nm);
      int n;
      n = 0;
      while ((q_m.size() != 0 || q_l.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, q_m.size() + q_l.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", v_m, 0);
      chk("reset_count", cnt_m, 0);
      chk("reset_pout", po_m, 0);
      chk("reset_ferr", fe_m, 0);
      chk("reset_ovf", ov_m, 0);
      reset_n = 1'b1;
      ready   = 1'b1;
      @(posedge clk); #1;

      // Back-to-back stream, MSB-first transmit.
      send_word(8'h00, 0, 8, 1, 1, 0);
      chk("latency_valid", v_m, 1);
      for (int k = 1; k < 14; k++) send_word(8'(k * 19), 0, 8, 1, 1, 0);
      send_word(8'hFE, 0, 8, 1, 1, 0);
      wait_drained("stream_drained");
      chk("stream_no_ferr", fe_n_m, 0);

      // LSB-first transmit proves bit order on both receivers.
      send_word(8'hA5, 1, 8, 1, 1, 0);
      send_word(8'h01, 1, 8, 1, 1, 0);
      wait_drained("order_drained");

      // Short word: marker on bit 5.
      send_word(8'hFF, 0, 5, 1, 0, 0);
      chk("short_ferr_pulse", fe_m, 1);
      chk("short_no_push", v_m, 0);
      @(posedge clk); #1;
      chk("short_ferr_one_cycle", fe_m, 0);
      send_word(8'h3C, 0, 8, 1, 1, 0);
      wait_drained("short_recover");
      chk("short_ferr_count", fe_n_m, 1);

      // Long word, then garbage in HUNT until a marker.
      send_word(8'hFF, 0, 8, 0, 0, 0);
      chk("long_ferr_pulse", fe_m, 1);
      send_word(8'hE0, 0, 3, 1, 0, 0);
      chk("hunt_no_push", v_m, 0);
      send_word(8'h5A, 0, 8, 1, 1, 0);
      wait_drained("long_recover");
      chk("long_ferr_count_m", fe_n_m, 2);
      chk("long_ferr_count_l", fe_n_l, 2);

      // Backpressure and overflow.
      ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send_word(8'(8'h10 + k), 0, 8, 1, 1, 0);
         chk("bp_count", cnt_m, k + 1);
      end
      send_word(8'h99, 0, 8, 1, 0, 0);
      chk("ovf_pulse", ov_m, 1);
      chk("ovf_count_held", cnt_m, 4);
      chk("ovf_head_stable", po_m, 8'h10);
      @(posedge clk); #1;
      chk("ovf_one_cycle", ov_m, 0);
      ready = 1'b1;
      wait_drained("bp_drain");
      chk("bp_empty", cnt_m, 0);

      // Full with simultaneous push and pop: no overflow.
      ready = 1'b0;
      for (int k = 0; k < 4; k++) send_word(8'(8'h20 + k), 0, 8, 1, 1, 0);
      send_word(8'h2F, 0, 8, 1, 1, 1);
      chk("pushpop_no_ovf", ov_m, 0);
      chk("pushpop_count", cnt_m, 4);
      wait_drained("pushpop_drain");
      chk("ovf_total_m", ov_n_m, 1);
      chk("ovf_total_l", ov_n_l, 1);

      // Reset mid-word with data queued.
      ready = 1'b0;
      send_word(8'h41, 0, 8, 1, 1, 0);
      send_word(8'h42, 0, 8, 1, 1, 0);
      send_word(8'h77, 0, 3, 0, 0, 0);
      chk("pre_reset_count", cnt_m, 2);
      reset_n = 1'b0;
      #1;
      chk("midreset_valid", v_m, 0);
      chk("midreset_count", cnt_m, 0);
      q_m.delete();
      q_l.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      ready   = 1'b1;
      send_word(8'hC3, 0, 8, 1, 1, 0);
      wait_drained("post_reset_word");
      chk("ferr_final_m", fe_n_m, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
